// File: rtl/seg7_pkg.sv
// Shared types, constants and BCD-to-segment lookup for the 7-segment scan controller.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {a,b,c,d,e,f,g}; non-decimal codes render as a blank digit.
    function automatic logic [6:0] seg7_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// Combinational 4-bit to active-low 7-segment decoder, shared across all digits.
module seg7_dec
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = seg7_decode(bcd);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed, double-buffered scan controller for a common-anode 7-segment bank.
// Optional leading-zero suppression is enabled by defining SEG7_LZ_SUPPRESS_EN.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done
);

    localparam int DW    = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    scan_state_t      state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic [IDX_W-1:0] idx, nxt_idx;

    logic [DW-1:0]         active, pending, commit_bcd;
    logic [NUM_DIGITS-1:0] dp_active, pend_dp, commit_dp;
    logic                  pend_valid;

    logic frame_end, commit, do_commit;
    logic [3:0] cur_bcd;
    logic       cur_dp, cur_blank;
    logic [6:0] dec_seg;

    logic [6:0]            seg_d;
    logic                  dp_d, fd_d;
    logic [NUM_DIGITS-1:0] an_d;

    assign frame_end = (state != ST_IDLE) && (cnt == CNT_LAST) && (idx == IDX_LAST);
    // Leaving IDLE counts as a frame boundary so a fresh scan starts on current data.
    assign commit    = en && ((state == ST_IDLE) || frame_end);
    assign do_commit = commit && (load || pend_valid);

    always_comb begin
        commit_bcd = load ? bcd_in : pending;
        commit_dp  = load ? dp_in  : pend_dp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            idx   <= nxt_idx;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_idx   = idx;
        if (!en) begin
            nxt_state = ST_IDLE;
            nxt_cnt   = '0;
            nxt_idx   = '0;
        end else if (state == ST_IDLE) begin
            nxt_cnt   = '0;
            nxt_idx   = '0;
            nxt_state = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;
        end else begin
            if (cnt == CNT_LAST) begin
                nxt_cnt = '0;
                nxt_idx = (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                nxt_cnt = cnt + 1'b1;
            end
            nxt_state = (nxt_cnt < CNT_BLANK) ? ST_BLANK : ST_DRIVE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active     <= '0;
            dp_active  <= '0;
            pending    <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
        end else if (commit) begin
            if (do_commit) begin
                active    <= commit_bcd;
                dp_active <= commit_dp;
            end
            pend_valid <= 1'b0;
        end else if (load) begin
            pending    <= bcd_in;
            pend_dp    <= dp_in;
            pend_valid <= 1'b1;
        end
    end

`ifdef SEG7_LZ_SUPPRESS_EN
    logic [NUM_DIGITS-1:0] lz_mask_q;

    // A digit is suppressed only when it and every more significant digit are zero.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [DW-1:0] v);
        logic [NUM_DIGITS-1:0] m;
        logic                  run;
        m   = '0;
        run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            run  = run && (v[4*k +: 4] == 4'd0);
            m[k] = run;
        end
        return m;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lz_mask_q <= '0;
        else if (do_commit)
            lz_mask_q <= lz_mask(commit_bcd);
    end
`endif

    always_comb begin
        cur_bcd   = active[3:0];
        cur_dp    = dp_active[0];
        cur_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_bcd = active[4*k +: 4];
                cur_dp  = dp_active[k];
`ifdef SEG7_LZ_SUPPRESS_EN
                cur_blank = lz_mask_q[k];
`endif
            end
        end
    end

    seg7_dec u_dec (
        .bcd (cur_bcd),
        .seg (dec_seg)
    );

    always_comb begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        an_d  = '1;
        fd_d  = frame_end && en;
        case (state)
            ST_DRIVE: begin
                an_d  = ~(NUM_DIGITS'(1) << idx);
                seg_d = cur_blank ? SEG_BLANK : dec_seg;
                dp_d  = ~cur_dp;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= SEG_BLANK;
            dp_n       <= 1'b1;
            an_n       <= '1;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_d;
            dp_n       <= dp_d;
            an_n       <= an_d;
            frame_done <= fd_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (4 digits, 8-cycle slots, 2-cycle blanking).
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_done;

    typedef struct {
        logic [3:0] an;
        logic [6:0] sg;
        logic       dp;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   passed = 0;
    int   e = 0;
    logic mon_on = 1'b0;

    seg7_scan_ctrl #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .seg        (seg),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_seg(input logic [3:0] v);
        case (v)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0100000;
            4'd7: return 7'b0001111;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic lz_blank(input logic [15:0] v, input int k);
`ifdef SEG7_LZ_SUPPRESS_EN
        logic z;
        z = 1'b1;
        for (int j = k; j < 4; j++) z = z && (v[4*j +: 4] == 4'd0);
        return (k >= 1) && z;
`else
        return 1'b0;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    task automatic applyStimulus(input logic ld, input logic [15:0] v, input logic [3:0] d);
        load   = ld;
        bcd_in = v;
        dp_in  = d;
    endtask

    task automatic push_digit(input logic [15:0] v, input logic [3:0] d, input int k, input int n);
        exp_t x;
        x.an = ~(4'b0001 << k);
        x.sg = lz_blank(v, k) ? 7'h7F : exp_seg(v[4*k +: 4]);
        x.dp = ~d[k];
        for (int i = 0; i < n; i++) expq.push_back(x);
    endtask

    task automatic push_frame(input logic [15:0] v, input logic [3:0] d);
        for (int k = 0; k < 4; k++) push_digit(v, d, k, 6);
    endtask

    task automatic goto(input int k);
        while (e < k) begin
            @(posedge clk);
            e++;
        end
        @(negedge clk);
    endtask

    task automatic check_off(input string tag);
        checkOutput({tag, "_an"},  32'(an_n),       32'hF);
        checkOutput({tag, "_seg"}, 32'(seg),        32'h7F);
        checkOutput({tag, "_dp"},  32'(dp_n),       32'h1);
        checkOutput({tag, "_fd"},  32'(frame_done), 32'h0);
    endtask

    // Monitor: every driven digit cycle is matched against the next scoreboard entry.
    int   cyc = 0;
    int   gap = 0;
    int   last_fd = -1;
    logic last_drive = 1'b0;
    logic have_drive = 1'b0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (an_n !== 4'hF) begin
                if (!last_drive && have_drive) checkOutput("blank_gap", 32'(gap), 32'd2);
                if (expq.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_drive: an_n=%b seg=%b, expected no drive", an_n, seg);
                end else begin
                    exp_t x;
                    x = expq.pop_front();
                    checkOutput("drive_an",  32'(an_n), 32'(x.an));
                    checkOutput("drive_seg", 32'(seg),  32'(x.sg));
                    checkOutput("drive_dp",  32'(dp_n), 32'(x.dp));
                end
                last_drive = 1'b1;
                have_drive = 1'b1;
                gap = 0;
            end else begin
                last_drive = 1'b0;
                gap++;
            end
            if (frame_done === 1'b1) begin
                checkOutput("fd_digit", 32'(an_n), 32'h7);
                if (last_fd >= 0) checkOutput("fd_period", 32'(cyc - last_fd), 32'd32);
                last_fd = cyc;
            end
            if (!en) begin
                have_drive = 1'b0;
                last_fd = -1;
            end
        end
        cyc++;
    end

    initial begin
        #50000;
        $display("[TB] FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        applyStimulus(1'b0, 16'h0, 4'h0);
        repeat (3) @(negedge clk);
        check_off("reset");
        rst_n  = 1'b1;
        mon_on = 1'b1;
        @(negedge clk);

        // Enable with a load in the same cycle: committed on IDLE exit.
        push_frame(16'h4321, 4'h0);
        push_frame(16'h4321, 4'h0);
        push_frame(16'h4321, 4'h0);
        applyStimulus(1'b1, 16'h4321, 4'h0);
        en = 1'b1;
        @(posedge clk);
        e = 0;
        @(negedge clk);
        applyStimulus(1'b0, 16'h0, 4'h0);
        checkOutput("start_an_c0", 32'(an_n), 32'hF);
        goto(1);
        checkOutput("start_an_c1", 32'(an_n), 32'hF);
        goto(2);
        checkOutput("start_an_c2", 32'(an_n), 32'hF);
        goto(3);
        checkOutput("first_drive_an",  32'(an_n), 32'hE);
        checkOutput("first_drive_seg", 32'(seg),  32'b1001111);
        goto(11);
        checkOutput("digit1_an",  32'(an_n), 32'hD);
        checkOutput("digit1_seg", 32'(seg),  32'b0010010);

        // Two mid-frame loads: the later one wins, and only at the next boundary.
        goto(65);
        applyStimulus(1'b1, 16'h1111, 4'h0);
        goto(66);
        applyStimulus(1'b0, 16'h0, 4'h0);
        goto(69);
        applyStimulus(1'b1, 16'h9876, 4'h0);
        push_frame(16'h9876, 4'h0);
        goto(70);
        applyStimulus(1'b0, 16'h0, 4'h0);

        // Load exactly on the boundary edge goes straight to the display.
        goto(127);
        applyStimulus(1'b1, 16'h00A5, 4'b0010);
        push_frame(16'h00A5, 4'b0010);
        push_digit(16'h00A5, 4'b0010, 0, 3);
        goto(128);
        applyStimulus(1'b0, 16'h0, 4'h0);

        // Drop enable mid-DRIVE, then restart from digit 0 blanking.
        goto(164);
        en = 1'b0;
        goto(166);
        check_off("disable");
        goto(169);
        en = 1'b1;
        push_frame(16'h00A5, 4'b0010);
        push_digit(16'h00A5, 4'b0010, 0, 2);
        goto(170);
        checkOutput("restart_an_c0", 32'(an_n), 32'hF);
        goto(171);
        checkOutput("restart_an_c1", 32'(an_n), 32'hF);
        goto(172);
        checkOutput("restart_an_c2", 32'(an_n), 32'hF);
        goto(173);
        checkOutput("restart_an",  32'(an_n), 32'hE);
        checkOutput("restart_seg", 32'(seg),  32'b0100100);
        checkOutput("restart_dp",  32'(dp_n), 32'h1);

        // Asynchronous reset mid-DRIVE clears buffers as well as the scan.
        goto(206);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        check_off("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_frame(16'h0000, 4'h0);
        en = 1'b1;
        @(posedge clk);
        e = 0;
        @(negedge clk);
        goto(1);
        checkOutput("post_reset_an_c1", 32'(an_n), 32'hF);
        goto(2);
        checkOutput("post_reset_an_c2", 32'(an_n), 32'hF);
        goto(3);
        checkOutput("post_reset_an",  32'(an_n), 32'hE);
        checkOutput("post_reset_seg", 32'(seg),  32'b0000001);
        goto(32);
        en = 1'b0;
        goto(40);
        checkOutput("queue_drained", 32'(expq.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
